// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM/timer output stage: default width and FSM states.
package pwm_timer_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_timer_irq.sv
// Sticky interrupt flag: a set in the same cycle as a clear wins; the mask only gates the output.
module pwm_timer_irq (
  input  logic slow_clk,
  input  logic rst,
  input  logic sw_rst,
  input  logic set,
  input  logic clr,
  input  logic en,
  output logic flag,
  output logic irq
);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (sw_rst) begin
      flag <= 1'b0;
    end else begin
      flag <= set | (flag & ~clr);
    end
  end

  assign irq = flag & en;

endmodule

// File: rtl/pwm_timer_out.sv
// PWM / timer output stage: shadowed period and duty, registered PWM compare,
// one-shot/continuous timer FSM and a sticky maskable interrupt.
module pwm_timer_out
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             sw_rst,
  input  logic             counter_en,
  input  logic             mode,
  input  logic             timer_mode,
  input  logic             out_en,
  input  logic             irq_en,
  input  logic             irq_clr,
  input  logic [CNT_W-1:0] counter,
  input  logic [CNT_W-1:0] period_reg,
  input  logic [CNT_W-1:0] duty_reg,
  output logic             o_pwm,
  output logic             o_irq,
  output logic             o_done,
  output state_t           fsm_state,
  output logic             irq_flag
);

  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] period_m1;
  logic             mode_q;
  logic             mode_chg;
  logic             period_ok;
  logic             shadow_ld;
  logic             evt_pwm;
  logic             evt_tmr;
  state_t           state;
  state_t           state_nxt;

  assign mode_chg  = (mode != mode_q);
  assign period_ok = (period_sh != '0);
  assign period_m1 = period_sh - CNT_W'(1);
  // Shadows only follow the register file while stopped or at the period start.
  assign shadow_ld = ~counter_en | (counter == '0);

  assign evt_pwm = mode & counter_en & period_ok & ~mode_chg & (counter == period_m1);
  assign evt_tmr = ~mode & counter_en & period_ok & ~mode_chg & (state == RUN) &
                   (counter == period_sh);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      period_sh <= '0;
      duty_sh   <= '0;
      mode_q    <= 1'b0;
      o_pwm     <= 1'b0;
    end else if (sw_rst) begin
      period_sh <= '0;
      duty_sh   <= '0;
      mode_q    <= 1'b0;
      o_pwm     <= 1'b0;
    end else begin
      mode_q <= mode;
      if (shadow_ld) begin
        period_sh <= period_reg;
        duty_sh   <= duty_reg;
      end
      // A stopped counter holds the last compare result.
      if (mode_chg || !mode) begin
        o_pwm <= 1'b0;
      end else if (counter_en) begin
        o_pwm <= out_en & (counter < duty_sh);
      end
    end
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (mode || mode_chg) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (counter_en) state_nxt = RUN;
        RUN: begin
          if (!counter_en) state_nxt = IDLE;
          else if (evt_tmr && !timer_mode) state_nxt = DONE;
        end
        DONE: if (!counter_en) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_done    = (state == DONE);
  assign fsm_state = state;

  pwm_timer_irq u_irq (
    .slow_clk (slow_clk),
    .rst      (rst),
    .sw_rst   (sw_rst),
    .set      (evt_pwm | evt_tmr),
    .clr      (irq_clr),
    .en       (irq_en),
    .flag     (irq_flag),
    .irq      (o_irq)
  );

endmodule
